// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared declarations for the reg_file_scan register file slice.
//   dump_state_t : dump port FSM states (IDLE, SCAN)
//   FLAG_*       : bit positions of the ALU flags in flag_in / flags_out
package reg_file_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } dump_state_t;

    localparam int FLAG_SCRY = 0;
    localparam int FLAG_NGTV = 1;
    localparam int FLAG_ZERO = 2;

endpackage

// File: rtl/reg_file_dump_fsm.sv
// reg_file_dump_fsm
// Sequencer for the register dump port. Walks an index from 0 to 2**PW-1,
// advancing one step per valid/ready handshake, then returns to IDLE.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   dump_req    : start request, sampled only in IDLE
//   dump_ready  : consumer accepts the current beat
//   dump_busy   : a dump is in progress
//   dump_valid  : current beat is valid
//   dump_last   : current beat is the final address
//   index       : address of the current beat, fed to the storage array
module reg_file_dump_fsm
    import reg_file_pkg::*;
#(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dump_req,
    input  logic          dump_ready,
    output logic          dump_busy,
    output logic          dump_valid,
    output logic          dump_last,
    output logic [PW-1:0] index
);

    dump_state_t   state_q, state_d;
    logic [PW-1:0] index_q, index_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Valid depends only on the registered state, so there is no path from
    // dump_ready to dump_valid. The index wraps to 0 after the last beat,
    // leaving it ready for the next dump.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = SCAN;
                    index_d = '0;
                end
            end
            SCAN: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                dump_last  = (index_q == {PW{1'b1}});
                if (dump_ready) begin
                    index_d = index_q + PW'(1);
                    if (dump_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    assign index = index_q;

endmodule

// File: rtl/reg_file_scan.sv
// reg_file_scan
// 2**PW x DW register file with two combinational read ports, one clocked
// write port, an NFLAG-bit ALU flag register with per-flag write enables,
// and a valid/ready dump port that streams every register in address order.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write/flag forwarding
// to the read ports and flags_out; the dump port is never forwarded).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  : register write port
//   flag_we/flag_in        : per-flag write enables and new flag values
//   rd_addr_a/rd_addr_b    : read addresses
//   rd_data_a/rd_data_b    : combinational read data
//   flags_out              : stored (or forwarded) flags
//   dump_req               : start a dump
//   dump_busy/dump_valid   : dump in progress / beat valid
//   dump_ready             : consumer accepts beat
//   dump_addr/dump_data    : current beat address and register contents
//   dump_last              : current beat is address 2**PW-1
module reg_file_scan
    import reg_file_pkg::*;
#(
    parameter int DW    = 8,
    parameter int PW    = 3,
    parameter int NFLAG = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic [NFLAG-1:0] flag_we,
    input  logic [NFLAG-1:0] flag_in,
    input  logic [PW-1:0]    rd_addr_a,
    input  logic [PW-1:0]    rd_addr_b,
    output logic [DW-1:0]    rd_data_a,
    output logic [DW-1:0]    rd_data_b,
    output logic [NFLAG-1:0] flags_out,
    input  logic             dump_req,
    output logic             dump_busy,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [PW-1:0]    dump_addr,
    output logic [DW-1:0]    dump_data,
    output logic             dump_last
);

    localparam int DEPTH = 1 << PW;

    logic [DW-1:0]    core [DEPTH];
    logic [NFLAG-1:0] flags_q;
    logic [PW-1:0]    dump_index;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                core[i] <= '0;
            end
        end else if (wr_en) begin
            core[wr_addr] <= wr_data;
        end
    end

    // Each flag bit holds unless its own write enable is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= (flag_we & flag_in) | (~flag_we & flags_q);
        end
    end

    always_comb begin
        rd_data_a = core[rd_addr_a];
        rd_data_b = core[rd_addr_b];
        flags_out = flags_q;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (wr_en && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
        flags_out = (flag_we & flag_in) | (~flag_we & flags_q);
`endif
    end

    reg_file_dump_fsm #(
        .PW(PW)
    ) u_dump_fsm (
        .clk       (clk),
        .reset     (reset),
        .dump_req  (dump_req),
        .dump_ready(dump_ready),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_last (dump_last),
        .index     (dump_index)
    );

    // The dump reads live storage, so a write to the stalled index shows up
    // on the following cycle. Address and data are zeroed outside a dump.
    assign dump_addr = dump_valid ? dump_index : '0;
    assign dump_data = dump_valid ? core[dump_index] : '0;

endmodule

// File: tb/tb_reg_file_scan.sv
// tb_reg_file_scan
// Self-checking bench for reg_file_scan: a table of read/write/flag vectors
// plus directed dump sequences (full dump, stalls with a write to the
// stalled index, reset mid-dump, dump_req pulsed during a scan).
module tb_reg_file_scan;

    localparam int DW    = 8;
    localparam int PW    = 3;
    localparam int NFLAG = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NFLAG-1:0] flag_we;
    logic [NFLAG-1:0] flag_in;
    logic [PW-1:0]    rd_addr_a;
    logic [PW-1:0]    rd_addr_b;
    logic [DW-1:0]    rd_data_a;
    logic [DW-1:0]    rd_data_b;
    logic [NFLAG-1:0] flags_out;
    logic             dump_req;
    logic             dump_busy;
    logic             dump_valid;
    logic             dump_ready;
    logic [PW-1:0]    dump_addr;
    logic [DW-1:0]    dump_data;
    logic             dump_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_scan #(
        .DW(DW), .PW(PW), .NFLAG(NFLAG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .flags_out (flags_out),
        .dump_req  (dump_req),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .dump_last (dump_last)
    );

    // Inputs applied in one cycle; expected values are the stored state seen
    // before that cycle's edge captures the write/flag update.
    typedef struct {
        logic             wr_en;
        logic [PW-1:0]    wr_addr;
        logic [DW-1:0]    wr_data;
        logic [NFLAG-1:0] flag_we;
        logic [NFLAG-1:0] flag_in;
        logic [PW-1:0]    rd_addr_a;
        logic [PW-1:0]    rd_addr_b;
        logic [DW-1:0]    exp_a;
        logic [DW-1:0]    exp_b;
        logic [NFLAG-1:0] exp_flags;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [DW-1:0]    ea;
        logic [DW-1:0]    eb;
        logic [NFLAG-1:0] ef;
        wr_en     = v.wr_en;
        wr_addr   = v.wr_addr;
        wr_data   = v.wr_data;
        flag_we   = v.flag_we;
        flag_in   = v.flag_in;
        rd_addr_a = v.rd_addr_a;
        rd_addr_b = v.rd_addr_b;
        ea = v.exp_a;
        eb = v.exp_b;
        ef = v.exp_flags;
`ifdef REGFILE_BYPASS_EN
        if (v.wr_en && v.rd_addr_a == v.wr_addr) ea = v.wr_data;
        if (v.wr_en && v.rd_addr_b == v.wr_addr) eb = v.wr_data;
        ef = (v.flag_we & v.flag_in) | (~v.flag_we & v.exp_flags);
`endif
        #1;
        checkOutput("rd_data_a", 32'(rd_data_a), 32'(ea));
        checkOutput("rd_data_b", 32'(rd_data_b), 32'(eb));
        checkOutput("flags_out", 32'(flags_out), 32'(ef));
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        flag_we = '0;
    endtask

    task automatic writeReg(input logic [PW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic checkBeat(input string name, input int a, input logic [DW-1:0] d,
                             input logic last);
        checkOutput({name, " valid"}, 32'(dump_valid), 32'd1);
        checkOutput({name, " busy"},  32'(dump_busy),  32'd1);
        checkOutput({name, " addr"},  32'(dump_addr),  32'(a));
        checkOutput({name, " data"},  32'(dump_data),  32'(d));
        checkOutput({name, " last"},  32'(dump_last),  32'(last));
    endtask

    task automatic startDump();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
    endtask

    initial begin
        int beats;
        logic saw_last;

        vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'b000, 3'b000, 3'd3, 3'd3, 8'h00, 8'h00, 3'b000};
        vecs[1] = '{1'b0, 3'd0, 8'h00, 3'b000, 3'b000, 3'd3, 3'd3, 8'hA5, 8'hA5, 3'b000};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 3'b010, 3'b111, 3'd3, 3'd0, 8'hA5, 8'h00, 3'b000};
        vecs[3] = '{1'b0, 3'd0, 8'h00, 3'b000, 3'b000, 3'd3, 3'd0, 8'hA5, 8'h00, 3'b010};
        vecs[4] = '{1'b1, 3'd5, 8'h3C, 3'b000, 3'b111, 3'd5, 3'd3, 8'h00, 8'hA5, 3'b010};
        vecs[5] = '{1'b0, 3'd0, 8'h00, 3'b000, 3'b000, 3'd5, 3'd5, 8'h3C, 8'h3C, 3'b010};
        vecs[6] = '{1'b0, 3'd0, 8'h00, 3'b101, 3'b001, 3'd0, 3'd7, 8'h00, 8'h00, 3'b010};
        vecs[7] = '{1'b1, 3'd7, 8'h80, 3'b000, 3'b000, 3'd7, 3'd5, 8'h00, 8'h3C, 3'b011};
        vecs[8] = '{1'b0, 3'd0, 8'h00, 3'b111, 3'b000, 3'd7, 3'd7, 8'h80, 8'h80, 3'b011};
        vecs[9] = '{1'b0, 3'd0, 8'h00, 3'b000, 3'b000, 3'd7, 3'd3, 8'h80, 8'hA5, 3'b000};

        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        flag_we    = '0;
        flag_in    = '0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("reset rd_data_a", 32'(rd_data_a), 32'd0);
        checkOutput("reset flags", 32'(flags_out), 32'd0);
        checkOutput("reset valid", 32'(dump_valid), 32'd0);
        checkOutput("reset busy", 32'(dump_busy), 32'd0);
        checkOutput("reset dump_addr", 32'(dump_addr), 32'd0);
        checkOutput("reset last", 32'(dump_last), 32'd0);

        // Read/write/flag vector table
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Full dump with ready held high
        for (int i = 0; i < 8; i++) writeReg(PW'(i), 8'h10 + DW'(i));
        dump_ready = 1'b1;
        startDump();
        for (int i = 0; i < 8; i++) begin
            checkBeat("full", i, 8'h10 + DW'(i), i == 7);
            tick();
        end
        checkOutput("full busy after", 32'(dump_busy), 32'd0);
        checkOutput("full valid after", 32'(dump_valid), 32'd0);

        // Stalled dump with a write into the stalled index
        dump_ready = 1'b1;
        startDump();
        checkBeat("stall b0", 0, 8'h10, 1'b0);
        tick();
        dump_ready = 1'b0;
        checkBeat("stall b1 s0", 1, 8'h11, 1'b0);
        tick();
        checkBeat("stall b1 s1", 1, 8'h11, 1'b0);
        tick();
        dump_ready = 1'b1;
        checkBeat("stall b1 hs", 1, 8'h11, 1'b0);
        tick();
        dump_ready = 1'b0;
        checkBeat("stall b2 pre", 2, 8'h12, 1'b0);
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        checkBeat("stall b2 upd", 2, 8'hFF, 1'b0);
        dump_ready = 1'b1;
        tick();
        for (int i = 3; i < 8; i++) begin
            checkBeat("stall tail", i, 8'h10 + DW'(i), i == 7);
            tick();
        end
        checkOutput("stall busy after", 32'(dump_busy), 32'd0);

        // Reset at beat 4, with a write that reset must override
        startDump();
        for (int i = 0; i < 4; i++) tick();
        checkBeat("rst b4", 4, 8'h14, 1'b0);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 8'h55;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        checkOutput("rst valid", 32'(dump_valid), 32'd0);
        checkOutput("rst busy", 32'(dump_busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = PW'(i);
            #1;
            checkOutput("rst reg clear", 32'(rd_data_a), 32'd0);
        end
        tick();
        checkOutput("rst no beats", 32'(dump_valid), 32'd0);

        // Fresh dump after reset; dump_req pulsed mid-scan must be ignored
        for (int i = 0; i < 8; i++) writeReg(PW'(i), 8'h20 + DW'(i));
        dump_ready = 1'b1;
        startDump();
        checkBeat("fresh b0", 0, 8'h20, 1'b0);
        beats    = 0;
        saw_last = 1'b0;
        for (int c = 0; c < 14; c++) begin
            dump_req = (c == 3);
            #1;
            if (dump_valid && dump_ready) begin
                checkOutput("seq addr", 32'(dump_addr), 32'(beats));
                checkOutput("seq data", 32'(dump_data), 32'(8'h20 + DW'(beats)));
                if (dump_last) saw_last = 1'b1;
                beats++;
            end
            tick();
        end
        dump_req = 1'b0;
        checkOutput("seq beat count", 32'(beats), 32'd8);
        checkOutput("seq saw last", 32'(saw_last), 32'd1);
        checkOutput("seq idle", 32'(dump_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_scan.md
# reg_file_scan

Parametrised successor to the core register file. It holds 2**PW general registers of DW bits, with two combinational read ports and one clocked write port. It also keeps an NFLAG-bit ALU flag register with per-flag write enables. A handshaked dump port streams every register out in address order for debug and scan-out.

## Interface
- DW, 8, register data width
- PW, 3, address width; depth = 2**PW
- NFLAG, 3, number of flag bits (bit 0 scry, bit 1 ngtv, bit 2 zero)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- wr_en  input  1  register write enable
- wr_addr  input  PW  write address
- wr_data  input  DW  write data
- flag_we  input  NFLAG  per-flag write enable
- flag_in  input  NFLAG  new flag values from ALU
- rd_addr_a, rd_addr_b  input  PW  read addresses
- rd_data_a, rd_data_b  output  DW  read data, combinational
- flags_out  output  NFLAG  stored flags
- dump_req  input  1  start a dump (pulse or level)
- dump_busy  output  1  dump in progress
- dump_valid  output  1  dump beat valid
- dump_ready  input  1  consumer accepts beat
- dump_addr  output  PW  address of current beat
- dump_data  output  DW  contents of register dump_addr
- dump_last  output  1  current beat is address 2**PW-1

## Operation
- Reset: all registers 0, flags 0, FSM IDLE, dump index 0. All outputs 0 except rd_data_*, which read 0s.
- Reset has priority over wr_en, flag_we and dump activity in the same cycle.
- Write: wr_en=1 stores wr_data at core[wr_addr]. The write is independent of the flags.
- Flags: each flags_out[i] loads flag_in[i] only when flag_we[i]=1. Otherwise it holds its value.
- Reads: rd_data_x = core[rd_addr_x]. Both ports may use the same address.
- Dump FSM states: IDLE, SCAN.
  - IDLE -> SCAN when dump_req=1. The index is set to 0.
  - In SCAN: dump_valid=1, dump_busy=1, dump_addr=index, dump_data=core[index] (live read), dump_last=(index==2**PW-1).
  - A beat completes on a cycle where dump_valid and dump_ready are both 1. The index then increments.
  - SCAN -> IDLE when the beat with dump_last=1 completes.
  - dump_req in SCAN is ignored, and no restart occurs. If dump_req is still high in IDLE after completion, a new dump starts.
- Writes during a dump are legal. If a write targets the current index while the beat is stalled, dump_data updates the next cycle. The consumer's value is whatever is present at handshake.
- Reset mid-dump: the FSM returns to IDLE next edge, dump_valid=0, and no further beats are produced.

## Timing
- A write or flag update is visible on rd_data_*/flags_out in the cycle after the edge it is captured on. With bypass compiled in, it is visible in the same cycle.
- dump_req is sampled at edge N. The first beat is valid in cycle N+1.
- With dump_ready held at 1, a dump takes 2**PW cycles of valid. dump_busy falls the cycle after the last handshake.
- dump_ready low stalls the beat indefinitely. dump_addr holds during a stall.
- There is no combinational path from dump_ready to dump_valid.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle forwarding is compiled in.
  - When wr_en=1 and rd_addr_x==wr_addr, rd_data_x returns wr_data.
  - flags_out[i] returns flag_in[i] when flag_we[i]=1.
  - The dump port is never bypassed.
- Undefined: reads and flags return stored state only.

## Structure
- Shared package reg_file_pkg holds:
  - the dump state typedef (IDLE, SCAN)
  - flag index constants FLAG_SCRY=0, FLAG_NGTV=1, FLAG_ZERO=2
- Sub-module reg_file_dump_fsm contains the state, the index counter and the handshake logic. It outputs the index to the storage array.

## Test plan
- Reset, then write 8'hA5 to r3, then read both ports at 3 -> 8'hA5 next cycle. With bypass, 8'hA5 appears in the same cycle.
- flag_we=3'b010, flag_in=3'b111 from flags 000 -> flags_out=3'b010. A register write alone leaves flags unchanged.
- Load r0..r7 with 8'h10..8'h17, pulse dump_req, hold ready=1 -> 8 beats with addr 0..7 and data 10..17. dump_last is set on beat 7. busy falls on the following cycle.
- Dump with ready toggling 1,0,0,1: addr/data hold during stalls. During a stall, write r2=8'hFF while index=2 -> the beat hands off 8'hFF.
- Assert reset at beat 4 of a dump -> valid=0 and busy=0 next cycle, all registers read 0. A fresh dump then starts at addr 0.
- dump_req pulsed during SCAN -> ignored, exactly one sequence of 8 beats.
